// File: rtl/clause_pkg.sv
// Shared widths, types and FSM encoding for the clause dispatch buffer and
// the engine-side queues that reuse its head-window mux.
package clause_pkg;

  localparam int LIT_IDX_MAX     = 1024;
  localparam int CLA_LENGTH      = 3;
  localparam int NUM_ENGINE      = 4;
  localparam int VARIABLE_LENGTH = $clog2(LIT_IDX_MAX) + 1;
  localparam int CLA_W           = CLA_LENGTH * VARIABLE_LENGTH;
  localparam int DEPTH           = 16;
  localparam int PTR_W           = $clog2(DEPTH);
  localparam int CNT_W           = PTR_W + 1;
  localparam int ENG_CNT_W       = $clog2(NUM_ENGINE) + 1;

  typedef logic [CLA_W-1:0]     clause_t;
  typedef logic [ENG_CNT_W-1:0] eng_cnt_t;
  typedef logic [PTR_W-1:0]     ptr_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } dispatch_state_e;

endpackage

// File: rtl/clause_window_mux.sv
// Combinational head window: the up-to-NUM_ENGINE oldest entries starting at
// rd_ptr, zero-filled beyond the number of valid entries.
module clause_window_mux
  import clause_pkg::*;
(
  input  ptr_t                     rd_ptr,
  input  clause_t                  mem [DEPTH],
  input  cnt_t                     count,
  output clause_t [NUM_ENGINE-1:0] window,
  output eng_cnt_t                 cnt_out
);

  always_comb begin
    cnt_out = (count >= CNT_W'(NUM_ENGINE)) ? eng_cnt_t'(NUM_ENGINE) : eng_cnt_t'(count);
    for (int i = 0; i < NUM_ENGINE; i++) begin
      // NOTE: default every slot first so an invalid slot never holds a stale value (no latch).
      window[i] = '0;
      // Pointer arithmetic is PTR_W wide, so the index wraps 15 -> 0 by itself.
      if (eng_cnt_t'(i) < cnt_out) window[i] = mem[rd_ptr + ptr_t'(i)];
    end
  end

endmodule

// File: rtl/clause_dispatch_fifo.sv
// Multi-pop clause buffer feeding the arbiter: one push per cycle, up to
// NUM_ENGINE pops per cycle, end-of-stream tracking and sticky protocol errors.
module clause_dispatch_fifo
  import clause_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_valid,
  input  clause_t                  push_clause,
  output logic                     push_ready,
  input  logic                     load_done,
  output clause_t [NUM_ENGINE-1:0] clause_distributed,
  output eng_cnt_t                 clause_cnt_out,
  input  eng_cnt_t                 clause_accept_in,
  output logic                     dispatch_en,
  output logic                     all_dispatched,
  output logic                     err_push_ovf,
  output logic                     err_pop_unf
);

  clause_t         mem [DEPTH];
  ptr_t            rd_ptr;
  ptr_t            wr_ptr;
  cnt_t            count;
  cnt_t            count_next;
  dispatch_state_e state;
  logic            push_fire;
  logic            pop_unf;
  eng_cnt_t        pop;

  // Everything the arbiter sees is derived from registered state only.
  always_comb begin
    push_ready = (count < CNT_W'(DEPTH)) && (state != FLUSH);
    push_fire  = push_valid && push_ready;
    pop_unf    = clause_accept_in > clause_cnt_out;
    pop        = pop_unf ? clause_cnt_out : clause_accept_in;
    count_next = count + CNT_W'(push_fire) - CNT_W'(pop);
  end

  assign dispatch_en    = (state == STREAM) || (state == FLUSH);
  assign all_dispatched = (state == DONE);

  // NOTE: the storage array is deliberately left out of reset; validity is
  // tracked by count, and a resettable array would cost a reset net per bit.
  always_ff @(posedge clock) begin
    if (push_fire) mem[wr_ptr] <= push_clause;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      state        <= IDLE;
      err_push_ovf <= 1'b0;
      err_pop_unf  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      if (push_fire) wr_ptr <= wr_ptr + ptr_t'(1);
      rd_ptr <= rd_ptr + ptr_t'(pop);
      count  <= count_next;
      if (pop_unf) err_pop_unf <= 1'b1;
      // Refusal during FLUSH is expected back-pressure, not an overflow.
      if (push_valid && !push_ready && state != FLUSH) err_push_ovf <= 1'b1;

      case (state)
        IDLE: begin
          if (load_done)      state <= (count_next == '0) ? DONE : FLUSH;
          else if (push_fire) state <= STREAM;
        end
        STREAM: begin
          if (load_done) state <= (count_next == '0) ? DONE : FLUSH;
        end
        FLUSH: begin
          if (count_next == '0) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  clause_window_mux u_window (
    .rd_ptr  (rd_ptr),
    .mem     (mem),
    .count   (count),
    .window  (clause_distributed),
    .cnt_out (clause_cnt_out)
  );

endmodule

// File: tb/tb_clause_dispatch_fifo.sv
// Directed bench for clause_dispatch_fifo: push/pop/window, full, wrap,
// simultaneous push+pop, flush/done sequencing, errors and reset abort.
module tb_clause_dispatch_fifo;
  import clause_pkg::*;

  logic                     clock;
  logic                     reset;
  logic                     push_valid;
  clause_t                  push_clause;
  logic                     push_ready;
  logic                     load_done;
  clause_t [NUM_ENGINE-1:0] window;
  eng_cnt_t                 cnt_out;
  eng_cnt_t                 accept;
  logic                     dispatch_en;
  logic                     all_dispatched;
  logic                     err_push_ovf;
  logic                     err_pop_unf;

  int vectors     = 0;
  int miscompares = 0;

  clause_dispatch_fifo dut (
    .clock              (clock),
    .reset              (reset),
    .push_valid         (push_valid),
    .push_clause        (push_clause),
    .push_ready         (push_ready),
    .load_done          (load_done),
    .clause_distributed (window),
    .clause_cnt_out     (cnt_out),
    .clause_accept_in   (accept),
    .dispatch_en        (dispatch_en),
    .all_dispatched     (all_dispatched),
    .err_push_ovf       (err_push_ovf),
    .err_pop_unf        (err_pop_unf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one cycle of inputs and sample 1 ns after the edge.
  task automatic step(input logic pv, input clause_t pc, input logic ld, input eng_cnt_t acc);
    push_valid  = pv;
    push_clause = pc;
    load_done   = ld;
    accept      = acc;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    push_valid = 1'b0; push_clause = '0; load_done = 1'b0; accept = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if (push_ready !== 1'b1 || cnt_out !== 3'd0 || window !== '0 || dispatch_en !== 1'b0 ||
        all_dispatched !== 1'b0 || err_push_ovf !== 1'b0 || err_pop_unf !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: rdy=%b cnt=%0d win=%h en=%b done=%b ovf=%b unf=%b, want rdy=1 others 0",
               tag, push_ready, cnt_out, window, dispatch_en, all_dispatched, err_push_ovf, err_pop_unf);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_outputs("reset_state");
  endtask

  task automatic test_push();
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, clause_t'(k), 1'b0, 3'd0);
      if (k == 1) begin
        vectors++;
        if (dispatch_en !== 1'b1 || cnt_out !== 3'd1) begin
          miscompares++;
          $display("FAIL push_first: en=%b cnt=%0d, want en=1 cnt=1", dispatch_en, cnt_out);
        end
      end
      if (k == 4) begin
        vectors++;
        if (cnt_out !== 3'd4) begin
          miscompares++;
          $display("FAIL push_cnt4: got %0d want 4", cnt_out);
        end
      end
    end
    vectors++;
    if (cnt_out !== 3'd4 || window !== {33'h4, 33'h3, 33'h2, 33'h1}) begin
      miscompares++;
      $display("FAIL push_window5: cnt=%0d win=%h want cnt=4 win={4,3,2,1}", cnt_out, window);
    end
  endtask

  task automatic test_pop();
    step(1'b0, '0, 1'b0, 3'd3);
    vectors++;
    if (cnt_out !== 3'd2 || window !== {33'h0, 33'h0, 33'h5, 33'h4} || dut.count !== 5'd2) begin
      miscompares++;
      $display("FAIL pop3: cnt=%0d count=%0d win=%h want cnt=2 count=2 win={0,0,5,4}",
               cnt_out, dut.count, window);
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < 14; k++) step(1'b1, clause_t'(32'h10 + k), 1'b0, 3'd0);
    vectors++;
    if (push_ready !== 1'b0 || dut.count !== 5'd16 || err_push_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL full_reach: rdy=%b count=%0d ovf=%b want rdy=0 count=16 ovf=0",
               push_ready, dut.count, err_push_ovf);
    end
    step(1'b1, clause_t'(33'h0BAD), 1'b0, 3'd0);
    vectors++;
    if (err_push_ovf !== 1'b1 || dut.count !== 5'd16 ||
        window !== {33'h11, 33'h10, 33'h5, 33'h4}) begin
      miscompares++;
      $display("FAIL full_overflow: ovf=%b count=%0d win=%h want ovf=1 count=16 win={11,10,5,4}",
               err_push_ovf, dut.count, window);
    end
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b0, 3'd4);
    vectors++;
    if (cnt_out !== 3'd0 || push_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL full_drain: cnt=%0d rdy=%b want cnt=0 rdy=1", cnt_out, push_ready);
    end
  endtask

  // rd_ptr = wr_ptr = 3 on entry; build 8 entries at 6..13 with wr_ptr = 14.
  task automatic test_wrap();
    for (int k = 0; k < 11; k++) step(1'b1, clause_t'(32'h20 + k), 1'b0, 3'd0);
    step(1'b0, '0, 1'b0, 3'd3);
    vectors++;
    if (window !== {33'h26, 33'h25, 33'h24, 33'h23} || dut.count !== 5'd8) begin
      miscompares++;
      $display("FAIL wrap_setup: win=%h count=%0d want {26,25,24,23} count=8", window, dut.count);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, clause_t'(32'h30 + k), 1'b0, 3'd2);
      if (k == 2) begin
        vectors++;
        if (window !== {33'h31, 33'h30, 33'h2A, 33'h29} || dut.count !== 5'd5) begin
          miscompares++;
          $display("FAIL wrap_mid: win=%h count=%0d want {31,30,2a,29} count=5", window, dut.count);
        end
      end
    end
    vectors++;
    if (window !== {33'h33, 33'h32, 33'h31, 33'h30} || dut.count !== 5'd4) begin
      miscompares++;
      $display("FAIL wrap_end: win=%h count=%0d want {33,32,31,30} count=4", window, dut.count);
    end
    step(1'b0, '0, 1'b0, 3'd4);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) step(1'b1, clause_t'(32'h40 + k), 1'b0, 3'd0);
    step(1'b1, clause_t'(33'h43), 1'b0, 3'd3);
    vectors++;
    if (cnt_out !== 3'd1 || window !== {33'h0, 33'h0, 33'h0, 33'h43}) begin
      miscompares++;
      $display("FAIL push_pop_same: cnt=%0d win=%h want cnt=1 win={0,0,0,43}", cnt_out, window);
    end
    step(1'b0, '0, 1'b0, 3'd1);
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b1, clause_t'(33'h50), 1'b0, 3'd0);
    step(1'b1, clause_t'(33'h51), 1'b0, 3'd0);
    step(1'b0, '0, 1'b1, 3'd0);
    vectors++;
    if (dispatch_en !== 1'b1 || push_ready !== 1'b0 || cnt_out !== 3'd2 || all_dispatched !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_enter: en=%b rdy=%b cnt=%0d done=%b want en=1 rdy=0 cnt=2 done=0",
               dispatch_en, push_ready, cnt_out, all_dispatched);
    end
    // Push offered during FLUSH is refused silently.
    step(1'b1, clause_t'(33'h7F), 1'b0, 3'd1);
    vectors++;
    if (cnt_out !== 3'd1 || window[0] !== 33'h51 || err_push_ovf !== 1'b0 ||
        dispatch_en !== 1'b1 || all_dispatched !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_cycle1: cnt=%0d w0=%h ovf=%b en=%b done=%b want cnt=1 w0=51 ovf=0 en=1 done=0",
               cnt_out, window[0], err_push_ovf, dispatch_en, all_dispatched);
    end
    step(1'b0, '0, 1'b0, 3'd1);
    vectors++;
    if (all_dispatched !== 1'b1 || dispatch_en !== 1'b0 || cnt_out !== 3'd0) begin
      miscompares++;
      $display("FAIL flush_done: done=%b en=%b cnt=%0d want done=1 en=0 cnt=0",
               all_dispatched, dispatch_en, cnt_out);
    end
    step(1'b0, '0, 1'b1, 3'd0);
    vectors++;
    if (all_dispatched !== 1'b0 || dispatch_en !== 1'b0 || dut.state !== IDLE || err_pop_unf !== 1'b0) begin
      miscompares++;
      $display("FAIL done_to_idle: done=%b en=%b state=%0d unf=%b want done=0 en=0 state=0 unf=0",
               all_dispatched, dispatch_en, dut.state, err_pop_unf);
    end
  endtask

  task automatic test_underflow();
    step(1'b1, clause_t'(33'h60), 1'b0, 3'd0);
    step(1'b0, '0, 1'b0, 3'd2);
    vectors++;
    if (err_pop_unf !== 1'b1 || cnt_out !== 3'd0 || dut.count !== 5'd0) begin
      miscompares++;
      $display("FAIL pop_underflow: unf=%b cnt=%0d count=%0d want unf=1 cnt=0 count=0",
               err_pop_unf, cnt_out, dut.count);
    end
    step(1'b0, '0, 1'b0, 3'd0);
    vectors++;
    if (err_pop_unf !== 1'b1) begin
      miscompares++;
      $display("FAIL unf_sticky: unf=%b want 1", err_pop_unf);
    end
  endtask

  task automatic test_empty_problem();
    do_reset();
    step(1'b0, '0, 1'b1, 3'd0);
    vectors++;
    if (all_dispatched !== 1'b1 || dispatch_en !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_done: done=%b en=%b want done=1 en=0", all_dispatched, dispatch_en);
    end
    step(1'b0, '0, 1'b0, 3'd0);
    vectors++;
    if (all_dispatched !== 1'b0 || dut.state !== IDLE) begin
      miscompares++;
      $display("FAIL empty_idle: done=%b state=%0d want done=0 state=0", all_dispatched, dut.state);
    end
  endtask

  task automatic test_reset_mid_flush();
    for (int k = 0; k < 3; k++) step(1'b1, clause_t'(32'h70 + k), 1'b0, 3'd0);
    step(1'b1, clause_t'(33'h73), 1'b1, 3'd2);
    vectors++;
    if (dispatch_en !== 1'b1 || push_ready !== 1'b0 || err_pop_unf !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_abort_flush: en=%b rdy=%b unf=%b want en=1 rdy=0 unf=0",
               dispatch_en, push_ready, err_pop_unf);
    end
    step(1'b0, '0, 1'b0, 3'd3);
    vectors++;
    if (err_pop_unf !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_abort_unf: unf=%b want 1", err_pop_unf);
    end
    reset = 1'b1;
    step(1'b0, '0, 1'b0, 3'd0);
    reset = 1'b0;
    check_idle_outputs("reset_mid_flush");
  endtask

  initial begin
    reset = 1'b0;
    push_valid = 1'b0; push_clause = '0; load_done = 1'b0; accept = '0;
    test_reset();
    test_push();
    test_pop();
    test_full();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_underflow();
    test_empty_problem();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
